// File: rtl/sum_disp_pkg.sv
// Shared definitions for the sum BCD display slice.
//   state_t   : conversion FSM states
//   BCD_W     : width of the packed 4-digit BCD result
//   SEG_BLANK : active-low segment pattern with every segment off
//   SEG_LUT   : active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
package sum_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder, active-low outputs.
//   digit : BCD digit 0..9 (10..15 decode to blank)
//   blank : force all segments off
//   seg   : {g,f,e,d,c,b,a}, active-low
import sum_disp_pkg::*;

module bcd_to_seg7 (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // NOTE: seg gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) begin
      seg = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Captures an unsigned sum on a one-cycle valid pulse, converts it to four BCD
// digits with an iterative shift-add-3 (double dabble) FSM and drives a
// 4-digit multiplexed 7-segment display from the last completed result.
//   clk   : system clock, rising edge
//   rst   : synchronous, active-high reset
//   valid : one-cycle pulse, sum valid in the same cycle
//   sum   : binary value to convert
//   busy  : high while the FSM is shifting
//   done  : one-cycle pulse, bcd carries the new result in the same cycle
//   bcd   : {d3,d2,d1,d0} of the last completed conversion
//   an    : active-low one-hot digit enable, an[0] = least significant digit
//   seg   : active-low {g,f,e,d,c,b,a}, all ones = blank
import sum_disp_pkg::*;

module sum_bcd_display #(
  parameter int SUM_W    = 11,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int SH_W   = BCD_W + SUM_W;
  localparam int CNT_W  = $clog2(SUM_W + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  // One double-dabble step: correct every BCD nibble that would overflow
  // past 9 after doubling, then shift the whole register left.
  function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] t;
    t = s;
    for (int k = 0; k < 4; k++) begin
      if (t[SUM_W + 4*k +: 4] >= 4'd5) begin
        t[SUM_W + 4*k +: 4] = t[SUM_W + 4*k +: 4] + 4'd3;
      end
    end
    return t << 1;
  endfunction

  state_t           state, state_next;
  logic [SH_W-1:0]  sh;
  logic [SH_W-1:0]  sh_next;
  logic [CNT_W-1:0] cnt;
  logic             last_shift;
  logic             pending;
  logic [SUM_W-1:0] pend_sum;

  assign sh_next    = dabble(sh);
  assign last_shift = (cnt == CNT_W'(SUM_W - 1));

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (valid) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      // A valid arriving in DONE restarts directly, so no request is left
      // parked in pending while the FSM sits in IDLE.
      DONE:    state_next = (valid || pending) ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Datapath: shift register, step counter, result and one-deep pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      bcd      <= '0;
      pending  <= 1'b0;
      pend_sum <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            sh  <= {{BCD_W{1'b0}}, sum};
            cnt <= '0;
          end
        end
        SHIFT: begin
          sh  <= sh_next;
          cnt <= cnt + 1'b1;
          if (last_shift) bcd <= sh_next[SH_W-1:SUM_W];
          if (valid) begin
            pending  <= 1'b1;
            pend_sum <= sum;
          end
        end
        DONE: begin
          // The newest sum wins: a valid in this cycle beats the stored one.
          if (valid) begin
            sh      <= {{BCD_W{1'b0}}, sum};
            cnt     <= '0;
            pending <= 1'b0;
          end else if (pending) begin
            sh      <= {{BCD_W{1'b0}}, pend_sum};
            cnt     <= '0;
            pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx;
  logic [3:0]        digit;
  logic              blank;
  logic [6:0]        seg_dec;

  // Leading-zero blanking: digit k>0 is dark when it and all higher digits are 0.
  always_comb begin
    digit = bcd[4*idx +: 4];
    blank = 1'b0;
    if (BLANK_LZ != 0) begin
      unique case (idx)
        2'd3:    blank = (bcd[15:12] == 4'd0);
        2'd2:    blank = (bcd[15:8]  == 8'd0);
        2'd1:    blank = (bcd[15:4]  == 12'd0);
        default: blank = 1'b0;
      endcase
    end
  end

  bcd_to_seg7 u_dec (
    .digit (digit),
    .blank (blank),
    .seg   (seg_dec)
  );

  // an and seg are registered together so they always describe the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'hF;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_dec;
    end
  end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench for sum_bcd_display with a short scan period.
// Expected values come from decimal arithmetic on the input sum.
module tb_sum_bcd_display;

  localparam int SUM_W    = 11;
  localparam int SCAN_DIV = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid = 1'b0;
  logic [SUM_W-1:0] sum = '0;
  logic             busy, done;
  logic [15:0]      bcd;
  logic [3:0]       an;
  logic [6:0]       seg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sum_bcd_display #(
    .SUM_W    (SUM_W),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .sum   (sum),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .an    (an),
    .seg   (seg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] model_bcd(input int v);
    int r = 0;
    for (int k = 0; k < 4; k++) r = r + (((v / pow10(k)) % 10) << (4*k));
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input int v, input int k);
    if (k > 0 && v < pow10(k)) return 7'h7F;
    return seg_of((v / pow10(k)) % 10);
  endfunction

  // Pulse valid with value v and follow the conversion through cycle 12.
  task automatic run_conv(input int v);
    sum   = SUM_W'(v);
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("busy_c%0d_v%0d", c, v), busy, (c <= 11));
      check($sformatf("done_c%0d_v%0d", c, v), done, (c == 12));
      if (c == 12) check($sformatf("bcd_v%0d", v), bcd, model_bcd(v));
      if (c < 12) step();
    end
    step();
  endtask

  // Watch several full scan rotations and check each lit slot and its dwell time.
  task automatic check_display(input int v);
    logic [3:0] prev_an;
    int         run_len;
    int         k;
    logic [3:0] nxt;
    prev_an = an;
    run_len = -1;
    for (int c = 0; c < 5 * SCAN_DIV * 4; c++) begin
      step();
      case (an)
        4'hE: k = 0;
        4'hD: k = 1;
        4'hB: k = 2;
        4'h7: k = 3;
        default: k = -1;
      endcase
      check($sformatf("an_onehot_v%0d", v), (k >= 0), 1'b1);
      if (k >= 0) check($sformatf("seg_d%0d_v%0d", k, v), seg, model_seg(v, k));
      if (an != prev_an) begin
        nxt = {prev_an[2:0], prev_an[3]};
        check($sformatf("an_order_v%0d", v), an, nxt);
        if (run_len >= 0) check($sformatf("an_dwell_v%0d", v), run_len, SCAN_DIV);
        run_len = 1;
      end else if (run_len >= 0) begin
        run_len++;
      end
      prev_an = an;
    end
  endtask

  initial begin
    int rv;

    // 1. Reset state and first lit digit.
    rst = 1'b1;
    step();
    step();
    check("rst_an",   an,   4'hF);
    check("rst_seg",  seg,  7'h7F);
    check("rst_bcd",  bcd,  16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    step();
    check("rel_an",  an,  4'hE);
    check("rel_seg", seg, seg_of(0));
    check_display(0);

    // 2. Typical value.
    run_conv(1240);
    check_display(1240);

    // 3. Leading-zero blanking.
    run_conv(5);
    check_display(5);

    // 4. Extremes.
    run_conv(2047);
    check_display(2047);
    run_conv(0);
    check_display(0);

    // 5. Pending slot: 300 is overwritten by 14 before the first result.
    sum = 11'd100;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 3) begin sum = 11'd300; valid = 1'b1; end
      else if (c == 5) begin sum = 11'd14; valid = 1'b1; end
      else valid = 1'b0;
      check($sformatf("pend_done_c%0d", c), done, (c == 12 || c == 24));
      check($sformatf("pend_busy_c%0d", c), busy, ((c >= 1 && c <= 11) || (c >= 13 && c <= 23)));
      if (c == 12) check("pend_bcd_first", bcd, 16'h0100);
      if (c == 24) check("pend_bcd_second", bcd, 16'h0014);
      step();
    end
    valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check("pend_no_extra_done", done, 1'b0);
      step();
    end
    check("pend_bcd_hold", bcd, 16'h0014);

    // 6. Reset in the middle of a conversion.
    sum = 11'd1015;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 1; c < 6; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check("abort_no_done", done, 1'b0);
      check("abort_no_busy", busy, 1'b0);
      step();
    end
    check("abort_bcd", bcd, 16'h0);
    run_conv(1015);
    check_display(1015);

    // Randomized values against the decimal model.
    for (int i = 0; i < 12; i++) begin
      rv = int'($urandom_range(0, 2047));
      run_conv(rv);
      if (i < 4) check_display(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
